sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param_if.sv | 39 +++
 rtl/sync_fifo_param.sv | 92 +++++++++
 tb/tb_sync_fifo_param.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if
//   Handshake/data bundle between a producer/consumer pair and sync_fifo_param.
//   Parameters : Depth (entries, power of two), Data_Width (word bits)
//   Signals    : wr_en, data_in, rd_en, clr_err      (client -> FIFO)
//                data_out, full, empty, almost_full,
//                almost_empty, count, overflow,
//                underflow                            (FIFO -> client)
//   Modports   : master (client side), slave (FIFO side)
interface sync_fifo_param_if #(
   parameter int Depth      = 256,
   parameter int Data_Width = 8
);
   localparam int Addr_Width = $clog2(Depth);

   logic                  wr_en;
   logic [Data_Width-1:0] data_in;
   logic                  rd_en;
   logic                  clr_err;
   logic [Data_Width-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [Addr_Width:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, data_in, rd_en, clr_err,
      input  data_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );

   modport slave (
      input  wr_en, data_in, rd_en, clr_err,
      output data_out, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock FIFO with occupancy count, programmable almost-full /
//   almost-empty thresholds and sticky overflow / underflow flags.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset (pointers, count, flags, data_out)
//     bus  - sync_fifo_param_if.slave (write/read handshake, data, status)
//   Build option:
//     SYNC_FIFO_FWFT_EN - first-word-fall-through: data_out shows mem[rd_ptr]
//                         combinationally and rd_en pops the shown word.
//                         Undefined: data_out is registered on each accepted
//                         read (1-cycle latency) and holds between reads.
module sync_fifo_param #(
   parameter int Depth      = 256,
   parameter int Data_Width = 8,
   parameter int Addr_Width = $clog2(Depth),
   parameter int AF_Level   = Depth - 4,
   parameter int AE_Level   = 4
) (
   input logic              clk,
   input logic              rst,
   sync_fifo_param_if.slave bus
);

   localparam logic [Addr_Width:0] FULL_CNT = (Addr_Width+1)'(Depth);
   localparam logic [Addr_Width:0] AF_CNT   = (Addr_Width+1)'(AF_Level);
   localparam logic [Addr_Width:0] AE_CNT   = (Addr_Width+1)'(AE_Level);

   logic [Data_Width-1:0] mem [Depth];
   logic [Addr_Width-1:0] wr_ptr;
   logic [Addr_Width-1:0] rd_ptr;
   logic [Addr_Width:0]   count;
   logic                  wr_acc;
   logic                  rd_acc;

   // Flags come from the count register only, so a same-cycle read never
   // frees room for a write while full.
   assign bus.count        = count;
   assign bus.full         = (count == FULL_CNT);
   assign bus.empty        = (count == '0);
   assign bus.almost_full  = (count >= AF_CNT);
   assign bus.almost_empty = (count <= AE_CNT);

   assign wr_acc = bus.wr_en & ~bus.full;
   assign rd_acc = bus.rd_en & ~bus.empty;

   // Storage has no reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= bus.data_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky errors: a new event in the same cycle as clr_err wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.overflow  <= 1'b0;
         bus.underflow <= 1'b0;
      end else begin
         bus.overflow  <= (bus.wr_en & bus.full)  | (bus.overflow  & ~bus.clr_err);
         bus.underflow <= (bus.rd_en & bus.empty) | (bus.underflow & ~bus.clr_err);
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign bus.data_out = mem[rd_ptr];
`else
   logic [Data_Width-1:0] dout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         dout_q <= '0;
      else if (rd_acc) dout_q <= mem[rd_ptr];
   end

   assign bus.data_out = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
//   Directed bench for sync_fifo_param at Depth=16, Data_Width=8,
//   AF_Level=12, AE_Level=4. Expected values are hand-derived constants.
//   Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_sync_fifo_param;

   logic clk;
   logic rst;
   int   errs;
   int   checks;

   sync_fifo_param_if #(.Depth(16), .Data_Width(8)) bus ();

   sync_fifo_param #(
      .Depth     (16),
      .Data_Width(8),
      .AF_Level  (12),
      .AE_Level  (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_word(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.data_in = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   // Returns the word popped by one accepted read, for either read mode.
   task automatic rd_word(output logic [7:0] d);
`ifdef SYNC_FIFO_FWFT_EN
      d = bus.data_out;
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
`else
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      d = bus.data_out;
`endif
   endtask

   initial begin
      logic [7:0] d;
      errs        = 0;
      checks      = 0;
      rst         = 1'b1;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.clr_err = 1'b0;
      bus.data_in = 8'h00;
      tick();
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_flags", {bus.full, bus.empty, bus.almost_full, bus.almost_empty}, 4'b0101);
      chk("rst_err", {bus.overflow, bus.underflow}, 2'b00);
`ifndef SYNC_FIFO_FWFT_EN
      chk("rst_dout", 32'(bus.data_out), 32'h00);
`endif
      rst = 1'b0;
      tick();

      // 1: reset mid-stream with 5 words stored
      for (int i = 0; i < 6; i++) wr_word(8'h11 + 8'(i));
      rd_word(d);
      chk("t1_pre_rd", 32'(d), 32'h11);
      chk("t1_pre_cnt", 32'(bus.count), 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("t1_async_cnt", 32'(bus.count), 32'd0);
      chk("t1_async_flags", {bus.empty, bus.almost_empty}, 2'b11);
`ifndef SYNC_FIFO_FWFT_EN
      chk("t1_async_dout", 32'(bus.data_out), 32'h00);
`endif
      rst = 1'b0;
      tick();
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk("t1_underflow", 32'(bus.underflow), 32'd1);
      chk("t1_cnt_after", 32'(bus.count), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("t1_dout_hold", 32'(bus.data_out), 32'h00);
`endif
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;

      // 2: fill, overflow, ordered drain
      for (int i = 0; i < 16; i++) begin
         wr_word(8'(i));
         chk($sformatf("t2_af_%0d", i + 1), 32'(bus.almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
      end
      chk("t2_full", 32'(bus.full), 32'd1);
      chk("t2_cnt16", 32'(bus.count), 32'd16);
      wr_word(8'hAA);
      chk("t2_overflow", 32'(bus.overflow), 32'd1);
      chk("t2_cnt_drop", 32'(bus.count), 32'd16);
      for (int i = 0; i < 16; i++) begin
         rd_word(d);
         chk($sformatf("t2_rd_%0d", i), 32'(d), 32'(i));
      end
      chk("t2_empty", 32'(bus.empty), 32'd1);
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("t2_ovf_clr", 32'(bus.overflow), 32'd0);

      // 3: steady write+read at count=3 across pointer wrap
      for (int i = 0; i < 3; i++) wr_word(8'h80 + 8'(i));
      for (int i = 0; i < 40; i++) begin
         bus.wr_en   = 1'b1;
         bus.rd_en   = 1'b1;
         bus.data_in = 8'h83 + 8'(i);
`ifdef SYNC_FIFO_FWFT_EN
         chk($sformatf("t3_rd_%0d", i), 32'(bus.data_out), 32'h80 + 32'(i));
         tick();
`else
         tick();
         chk($sformatf("t3_rd_%0d", i), 32'(bus.data_out), 32'h80 + 32'(i));
`endif
         chk($sformatf("t3_cnt_%0d", i), 32'(bus.count), 32'd3);
         chk($sformatf("t3_flags_%0d", i),
             {bus.full, bus.empty, bus.almost_full, bus.almost_empty}, 4'b0001);
      end
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd_word(d);
         chk($sformatf("t3_drain_%0d", i), 32'(d), 32'hA8 + 32'(i));
      end
      chk("t3_empty", 32'(bus.empty), 32'd1);

      // 4: simultaneous read+write while full
      for (int i = 0; i < 16; i++) wr_word(8'h20 + 8'(i));
      chk("t4_full", 32'(bus.full), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
      chk("t4_rd", 32'(bus.data_out), 32'h20);
`endif
      bus.wr_en   = 1'b1;
      bus.rd_en   = 1'b1;
      bus.data_in = 8'h55;
      tick();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
      chk("t4_rd", 32'(bus.data_out), 32'h20);
`endif
      chk("t4_cnt15", 32'(bus.count), 32'd15);
      chk("t4_overflow", 32'(bus.overflow), 32'd1);
      for (int i = 1; i < 16; i++) begin
         rd_word(d);
         chk($sformatf("t4_drain_%0d", i), 32'(d), 32'h20 + 32'(i));
      end
      chk("t4_empty", 32'(bus.empty), 32'd1);

      // 5: error clearing, set wins over clear
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("t5_ovf_clr", 32'(bus.overflow), 32'd0);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk("t5_unf_set", 32'(bus.underflow), 32'd1);
      bus.clr_err = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      chk("t5_unf_clr", 32'(bus.underflow), 32'd0);
      bus.clr_err = 1'b1;
      bus.rd_en   = 1'b1;
      tick();
      bus.clr_err = 1'b0;
      bus.rd_en   = 1'b0;
      chk("t5_set_wins", 32'(bus.underflow), 32'd1);
      chk("t5_ovf_quiet", 32'(bus.overflow), 32'd0);

`ifdef SYNC_FIFO_FWFT_EN
      // 6: first word falls through without rd_en
      wr_word(8'h3C);
      chk("t6_fwft_dout", 32'(bus.data_out), 32'h3C);
      chk("t6_not_empty", 32'(bus.empty), 32'd0);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk("t6_empty", 32'(bus.empty), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
